ex_stage_mc: RTL
================

Name: ex_stage_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle execute stage.
- Performs ALU ops, branch/jump resolution and iterative multiply/divide, then registers results into an EX/MEM pipeline register.
- Uses a valid/ready handshake on both sides, so the pipeline stalls upstream while mul/div runs.
- Sits between ID/EX and MEM. The ALU stays an instantiated sub-block; mul/div is new.

Parameters:
- XLEN, 32, datapath width (>=32; jump target uses pc[XLEN-1:28]).
- MD_BITS, 1, quotient/product bits per iteration (1 or 2); mul/div iterations = XLEN/MD_BITS.
- SIG_W, 32, control-signal bus width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill in-flight op and output register
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc, in_pc_4, in_ir, in_r1, in_r2, in_ext  in  XLEN each  operands/instruction
- in_signal  in  SIG_W  decoded control
- in_dst  in  5  destination register
- out_valid  out  1  output register holds a result
- out_ready  in  1  MEM accepts
- out_pc, out_ir, out_r, out_r2, out_hi  out  XLEN  registered results (out_hi = mul high / div remainder)
- out_signal  out  SIG_W  registered control, with bits 28-30 overwritten
- out_dst  out  5  registered destination
- new_pc  out  XLEN  registered next PC
- jb  out  1  registered redirect (qualified by out_valid)

Behaviour:
- Reset (async, rst_n=0): state IDLE, out_valid=0, every output register 0, mul/div counter 0.
- Signal fields (package constants):
  - Branch=1, Jmp=2, AluSrc=6, AluOp=11:8, XSrcR2=12, JR=14, BranchSel=20:19.
  - MD_EN=21, MD_OP=23:22 (00 mulu, 01 muls, 10 divu, 11 divs).
  - Bit 31 passes through.
- Operand select: X = XSrcR2 ? r2 : r1; Y = AluSrc ? ext : r2.
- Branch condition b from BranchSel: 0 equal, 1 not-equal, 2 ALU result[0], 3 never.
- Next PC, priority JR > Jmp > b > pc_4:
  - JR: r1.
  - Jmp: {pc[XLEN-1:28], ir[25:0], 2'b00}.
  - Branch: pc + (sext(ir[15:0]) << 2).
- jb = JR | Jmp | b.
- out_signal overrides: [28]=0, [29]=b, [30]=Jmp|JR.
- Output register load: out_en = !out_valid | out_ready.
- in_ready = (state==IDLE) & out_en & !flush.
- State IDLE:
  - Non-MD accepted op: output register loads next edge, so latency is 1.
  - MD accepted op: latch operands and control, go to BUSY, counter = XLEN/MD_BITS.
- State BUSY:
  - One iteration per cycle, counter decrements.
  - On counter==1, go to DONE.
- State DONE:
  - When out_en, load result (out_r = product low/quotient, out_hi = product high/remainder) and go to IDLE.
  - Otherwise hold in DONE.
  - jb=0 for MD ops.
- MD latency: accept edge to out_valid = XLEN/MD_BITS + 1 cycles, with no downstream stall.
- Signed ops: operate on magnitudes, then fix signs.
  - Quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend.
- Div by zero: quotient = all ones, remainder = dividend, no exception.
- Overflow case divs(MIN, -1): quotient = MIN, remainder = 0.
- out_valid falls when out_ready=1 and no new load occurs.
- flush: synchronous. Next edge out_valid=0, state=IDLE, and no acceptance that cycle. flush overrides all other events.
- Stall: while out_valid & !out_ready, all out_* hold stable.

Decomposition:
- Package ex_pkg holds: signal bit-index constants, MD_OP encodings, FSM state enum (IDLE/BUSY/DONE).
- One sub-module, md_unit: iterative mul/div with start/busy/done, parametrised by XLEN and MD_BITS.
- The existing ALU is instantiated unchanged.

Test Plan:
- ADD (AluOp add), r1=5, r2=7, out_ready=1 -> next cycle out_valid=1, out_r=12, jb=0, new_pc=in_pc_4.
- BEQ r1=r2=3, pc=0x100, ir[15:0]=0xFFFE -> jb=1, new_pc=0xF8, out_signal[29]=1; same with r1≠r2 -> jb=0, new_pc=pc_4.
- muls with r1=-3, r2=7, XLEN=32, MD_BITS=1:
  - in_ready=0 for 33 cycles.
  - Then out_r=0xFFFFFFEB, out_hi=0xFFFFFFFF.
  - A second in_valid held during the op is accepted only after completion.
- divs 7/-2 -> out_r=-3, out_hi=1; divu 9/0 -> out_r=0xFFFFFFFF, out_hi=9.
- Hold out_ready=0 with a result pending -> out_* stable, in_ready=0; release -> drains next cycle and accepts the following op.
- flush asserted mid-BUSY -> next cycle out_valid=0, state IDLE, in_ready=1. Also check that rst_n low mid-op clears all outputs immediately (asynchronously).

Source files
------------

// File: rtl/ex_stage_mc_pkg.sv
// rtl/ex_stage_mc_pkg.sv - shared constants and types for the multi-cycle execute stage
package ex_pkg;

  localparam int SIG_BRANCH  = 1;
  localparam int SIG_JMP     = 2;
  localparam int SIG_ALUSRC  = 6;
  localparam int SIG_ALUOP_LO = 8;
  localparam int SIG_ALUOP_HI = 11;
  localparam int SIG_XSRCR2  = 12;
  localparam int SIG_JR      = 14;
  localparam int SIG_BSEL_LO = 19;
  localparam int SIG_BSEL_HI = 20;
  localparam int SIG_MD_EN   = 21;
  localparam int SIG_MDOP_LO = 22;
  localparam int SIG_MDOP_HI = 23;
  localparam int SIG_RSVD    = 28;
  localparam int SIG_BTAKEN  = 29;
  localparam int SIG_JUMP    = 30;

  localparam logic [1:0] MD_MULU = 2'b00;
  localparam logic [1:0] MD_MULS = 2'b01;
  localparam logic [1:0] MD_DIVU = 2'b10;
  localparam logic [1:0] MD_DIVS = 2'b11;

  localparam logic [1:0] BSEL_EQ    = 2'd0;
  localparam logic [1:0] BSEL_NE    = 2'd1;
  localparam logic [1:0] BSEL_ALU   = 2'd2;
  localparam logic [1:0] BSEL_NEVER = 2'd3;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

endpackage

// File: rtl/ex_stage_mc_alu.sv
// rtl/ex_stage_mc_alu.sv - combinational ALU of the execute stage
module ex_alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  assign shamt = b_i[SH_W-1:0];

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SLT:  y_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: y_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
      ALU_LUI:  y_o = b_i << 16;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage_mc_md_unit.sv
// rtl/ex_stage_mc_md_unit.sv - iterative shift-add multiplier / restoring divider
module md_unit
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MD_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            ack_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] lo_o,
  output logic [XLEN-1:0] hi_o
);

  localparam int ITERS = XLEN / MD_BITS;
  localparam int CNT_W = $clog2(ITERS + 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic              div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, bz_q, bz_d;
  logic [2*XLEN-1:0] step_v;

  // One radix-2 step on {hi, lo}: shift-add for multiply, restoring subtract for divide.
  function automatic logic [2*XLEN-1:0] md_step(input logic div, input logic [2*XLEN-1:0] acc,
                                                input logic [XLEN-1:0] d);
    logic [XLEN:0]   t;
    logic [XLEN-1:0] q;
    if (div) begin
      t = acc[2*XLEN-1:XLEN-1];
      q = {acc[XLEN-2:0], 1'b0};
      if (t >= {1'b0, d}) begin
        t    = t - {1'b0, d};
        q[0] = 1'b1;
      end
      md_step = {t[XLEN-1:0], q};
    end else begin
      t = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, d} : '0);
      md_step = {t, acc[XLEN-1:1]};
    end
  endfunction

  logic            is_div, is_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign is_div    = (op_i == MD_DIVU) || (op_i == MD_DIVS);
  assign is_signed = (op_i == MD_MULS) || (op_i == MD_DIVS);
  assign a_neg     = is_signed & a_i[XLEN-1];
  assign b_neg     = is_signed & b_i[XLEN-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    step_v  = {hi_q, lo_q};
    case (state_q)
      IDLE: if (start_i) begin
        state_d = BUSY;
        cnt_d   = CNT_W'(ITERS);
        hi_d    = '0;
        lo_d    = is_div ? a_mag : b_mag;
        opnd_d  = is_div ? b_mag : a_mag;
        div_d   = is_div;
        neg_d   = a_neg ^ b_neg;
        rneg_d  = a_neg;
        bz_d    = (b_i == '0);
      end
      BUSY: begin
        for (int i = 0; i < MD_BITS; i++) step_v = md_step(div_q, step_v, opnd_q);
        {hi_d, lo_d} = step_v;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: if (ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  assign prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_s  = bz_q ? '1 : (neg_q ? -lo_q : lo_q);
  assign rem_s  = rneg_q ? -hi_q : hi_q;

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign lo_o   = div_q ? quo_s : prod_s[XLEN-1:0];
  assign hi_o   = div_q ? rem_s : prod_s[2*XLEN-1:XLEN];

endmodule

// File: rtl/ex_stage_mc.sv
// rtl/ex_stage_mc.sv - multi-cycle execute stage with valid/ready handshake and EX/MEM register
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MD_BITS = 1,
  parameter int SIG_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_pc_4,
  input  logic [XLEN-1:0]  in_ir,
  input  logic [XLEN-1:0]  in_r1,
  input  logic [XLEN-1:0]  in_r2,
  input  logic [XLEN-1:0]  in_ext,
  input  logic [SIG_W-1:0] in_signal,
  input  logic [4:0]       in_dst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_ir,
  output logic [XLEN-1:0]  out_r,
  output logic [XLEN-1:0]  out_r2,
  output logic [XLEN-1:0]  out_hi,
  output logic [SIG_W-1:0] out_signal,
  output logic [4:0]       out_dst,
  output logic [XLEN-1:0]  new_pc,
  output logic             jb
);

  logic [XLEN-1:0] x_op, y_op, alu_res, br_tgt, j_tgt, npc, md_lo, md_hi;
  logic            is_md, cond, b, jmp, jr, out_en, accept, alu_load, md_start, md_load;
  logic            md_busy, md_done;
  logic [SIG_W-1:0] sig_ovr;

  assign x_op = in_signal[SIG_XSRCR2] ? in_r2 : in_r1;
  assign y_op = in_signal[SIG_ALUSRC] ? in_ext : in_r2;

  ex_alu #(.XLEN(XLEN)) u_alu (
    .op_i (in_signal[SIG_ALUOP_HI:SIG_ALUOP_LO]),
    .a_i  (x_op),
    .b_i  (y_op),
    .y_o  (alu_res)
  );

  always_comb begin
    cond = 1'b0;
    case (in_signal[SIG_BSEL_HI:SIG_BSEL_LO])
      BSEL_EQ:    cond = (x_op == y_op);
      BSEL_NE:    cond = (x_op != y_op);
      BSEL_ALU:   cond = alu_res[0];
      BSEL_NEVER: cond = 1'b0;
      default:    cond = 1'b0;
    endcase
  end

  // Mul/div ops never redirect, so their control is stripped of branch/jump effects.
  assign is_md  = in_signal[SIG_MD_EN];
  assign b      = in_signal[SIG_BRANCH] & cond & ~is_md;
  assign jmp    = in_signal[SIG_JMP] & ~is_md;
  assign jr     = in_signal[SIG_JR] & ~is_md;
  assign br_tgt = in_pc + ({{(XLEN-16){in_ir[15]}}, in_ir[15:0]} << 2);
  assign j_tgt  = {in_pc[XLEN-1:28], in_ir[25:0], 2'b00};
  assign npc    = jr ? in_r1 : jmp ? j_tgt : b ? br_tgt : in_pc_4;

  always_comb begin
    sig_ovr             = in_signal;
    sig_ovr[SIG_RSVD]   = 1'b0;
    sig_ovr[SIG_BTAKEN] = b;
    sig_ovr[SIG_JUMP]   = jmp | jr;
  end

  assign out_en   = ~out_valid | out_ready;
  assign in_ready = ~md_busy & out_en & ~flush;
  assign accept   = in_valid & in_ready;
  assign alu_load = accept & ~is_md;
  assign md_start = accept & is_md;
  assign md_load  = md_done & out_en & ~flush;

  md_unit #(.XLEN(XLEN), .MD_BITS(MD_BITS)) u_md (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .start_i (md_start),
    .op_i    (in_signal[SIG_MDOP_HI:SIG_MDOP_LO]),
    .a_i     (x_op),
    .b_i     (y_op),
    .ack_i   (md_load),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .lo_o    (md_lo),
    .hi_o    (md_hi)
  );

  logic [XLEN-1:0]  md_pc_q, md_ir_q, md_r2_q, md_npc_q;
  logic [SIG_W-1:0] md_sig_q;
  logic [4:0]       md_dst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_pc_q  <= '0;
      md_ir_q  <= '0;
      md_r2_q  <= '0;
      md_npc_q <= '0;
      md_sig_q <= '0;
      md_dst_q <= '0;
    end else if (md_start) begin
      md_pc_q  <= in_pc;
      md_ir_q  <= in_ir;
      md_r2_q  <= in_r2;
      md_npc_q <= npc;
      md_sig_q <= sig_ovr;
      md_dst_q <= in_dst;
    end
  end

  logic             valid_q, valid_d, jb_q, jb_d;
  logic [XLEN-1:0]  pc_q, pc_d, ir_q, ir_d, r_q, r_d, r2_q, r2_d, hi_q, hi_d, npc_q, npc_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [4:0]       dst_q, dst_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    r_d     = r_q;
    r2_d    = r2_q;
    hi_d    = hi_q;
    sig_d   = sig_q;
    dst_d   = dst_q;
    npc_d   = npc_q;
    jb_d    = jb_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (alu_load) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      ir_d    = in_ir;
      r_d     = alu_res;
      r2_d    = in_r2;
      hi_d    = '0;
      sig_d   = sig_ovr;
      dst_d   = in_dst;
      npc_d   = npc;
      jb_d    = jr | jmp | b;
    end else if (md_load) begin
      valid_d = 1'b1;
      pc_d    = md_pc_q;
      ir_d    = md_ir_q;
      r_d     = md_lo;
      r2_d    = md_r2_q;
      hi_d    = md_hi;
      sig_d   = md_sig_q;
      dst_d   = md_dst_q;
      npc_d   = md_npc_q;
      jb_d    = 1'b0;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
      r_q     <= '0;
      r2_q    <= '0;
      hi_q    <= '0;
      sig_q   <= '0;
      dst_q   <= '0;
      npc_q   <= '0;
      jb_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      r_q     <= r_d;
      r2_q    <= r2_d;
      hi_q    <= hi_d;
      sig_q   <= sig_d;
      dst_q   <= dst_d;
      npc_q   <= npc_d;
      jb_q    <= jb_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_pc     = pc_q;
  assign out_ir     = ir_q;
  assign out_r      = r_q;
  assign out_r2     = r2_q;
  assign out_hi     = hi_q;
  assign out_signal = sig_q;
  assign out_dst    = dst_q;
  assign new_pc     = npc_q;
  assign jb         = jb_q;

endmodule
